// File: rtl/jelly_bean_taster.sv
// Slave-side jelly-bean taster: judges written recipes, returns the verdict on READ,
// and keeps saturating tallies plus a sticky alarm on a run of YUCKY beans.
//
// Streak tracker states
//   state      | meaning
//   ST_IDLE    | no YUCKY streak in progress (streak 0)
//   ST_STREAK  | 0 < streak < YUCKY_LIMIT, alarm not yet raised
//   ST_ALARMED | alarm raised; held until CLEAR or reset
module jelly_bean_taster #(
  parameter int CNT_W       = 8,
  parameter int YUCKY_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       flavor,
  input  logic [1:0]       color,
  input  logic             sugar_free,
  input  logic             sour,
  input  logic [1:0]       command,
  output logic [1:0]       taste,
  output logic [6:0]       recipe,
  output logic [CNT_W-1:0] yummy_cnt,
  output logic [CNT_W-1:0] yucky_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             alarm
);

  localparam logic [1:0] CMD_NO_OP = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam logic [1:0] TASTE_UNKNOWN = 2'd0;
  localparam logic [1:0] TASTE_YUMMY   = 2'd1;
  localparam logic [1:0] TASTE_YUCKY   = 2'd2;

  localparam int STRK_W = $clog2(YUCKY_LIMIT + 1);
  localparam logic [STRK_W-1:0] LIMIT_S = STRK_W'(YUCKY_LIMIT);
  localparam logic [STRK_W:0]   LIMIT_W = (STRK_W + 1)'(YUCKY_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAK  = 2'd1,
    ST_ALARMED = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [STRK_W-1:0] streak_q,  streak_d;
  logic [1:0]        verdict_q, verdict_d;
  logic [1:0]        taste_q,   taste_d;
  logic [6:0]        recipe_q,  recipe_d;
  logic [CNT_W-1:0]  yummy_q,   yummy_d;
  logic [CNT_W-1:0]  yucky_q,   yucky_d;
  logic [CNT_W-1:0]  err_q,     err_d;
  logic              alarm_q,   alarm_d;

  logic              wr_legal;
  logic              is_yucky;
  logic [STRK_W:0]   streak_inc;
  logic              hit_limit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wr_legal   = (flavor != 3'd0) && (flavor <= 3'd4) && (color != 2'd3);
  assign is_yucky   = ((flavor == 3'd4) && sour) ||
                      ((flavor == 3'd3) && !sugar_free && (color == 2'd1));
  assign streak_inc = (STRK_W + 1)'(streak_q) + (STRK_W + 1)'(1);
  assign hit_limit  = (streak_inc >= LIMIT_W);

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    verdict_d = verdict_q;
    recipe_d  = recipe_q;
    yummy_d   = yummy_q;
    yucky_d   = yucky_q;
    err_d     = err_q;
    alarm_d   = alarm_q;
    taste_d   = TASTE_UNKNOWN;

    // Unknown command encodings fall into default and behave as NO_OP.
    case (command)
      CMD_READ: taste_d = verdict_q;
      CMD_WRITE: begin
        if (!wr_legal) begin
          err_d = sat_inc(err_q);
        end else begin
          recipe_d = {flavor, color, sugar_free, sour};
          if (is_yucky) begin
            verdict_d = TASTE_YUCKY;
            yucky_d   = sat_inc(yucky_q);
            streak_d  = hit_limit ? LIMIT_S : streak_inc[STRK_W-1:0];
            if (hit_limit) begin
              alarm_d = 1'b1;
              state_d = ST_ALARMED;
            end else if (state_q != ST_ALARMED) begin
              state_d = ST_STREAK;
            end
          end else begin
            verdict_d = TASTE_YUMMY;
            yummy_d   = sat_inc(yummy_q);
            streak_d  = '0;
            if (state_q != ST_ALARMED) state_d = ST_IDLE;
          end
        end
      end
      CMD_CLEAR: begin
        state_d   = ST_IDLE;
        streak_d  = '0;
        verdict_d = TASTE_UNKNOWN;
        recipe_d  = '0;
        yummy_d   = '0;
        yucky_d   = '0;
        err_d     = '0;
        alarm_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      streak_q  <= '0;
      verdict_q <= TASTE_UNKNOWN;
      taste_q   <= TASTE_UNKNOWN;
      recipe_q  <= '0;
      yummy_q   <= '0;
      yucky_q   <= '0;
      err_q     <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      verdict_q <= verdict_d;
      taste_q   <= taste_d;
      recipe_q  <= recipe_d;
      yummy_q   <= yummy_d;
      yucky_q   <= yucky_d;
      err_q     <= err_d;
      alarm_q   <= alarm_d;
    end
  end

  assign taste     = taste_q;
  assign recipe    = recipe_q;
  assign yummy_cnt = yummy_q;
  assign yucky_cnt = yucky_q;
  assign err_cnt   = err_q;
  assign alarm     = alarm_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(command))
        else $error("jelly_bean_taster: X/Z on command, treated as NO_OP");
    end
  end
`endif

endmodule

// File: tb/tb_jelly_bean_taster.sv
// Bench for jelly_bean_taster: directed scenarios plus random traffic, checked
// against a rule-level model for a default instance and a CNT_W=2 / LIMIT=1 instance.
module tb_jelly_bean_taster;

  logic       clk;
  logic       rst_n;
  logic [2:0] flavor;
  logic [1:0] color;
  logic       sugar_free;
  logic       sour;
  logic [1:0] command;

  logic [1:0] taste_a,  taste_b;
  logic [6:0] recipe_a, recipe_b;
  logic [7:0] yum_a, yuk_a, err_a;
  logic [1:0] yum_b, yuk_b, err_b;
  logic       alarm_a, alarm_b;

  int checks = 0;
  int errors = 0;

  jelly_bean_taster #(.CNT_W(8), .YUCKY_LIMIT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .flavor(flavor), .color(color),
    .sugar_free(sugar_free), .sour(sour), .command(command),
    .taste(taste_a), .recipe(recipe_a), .yummy_cnt(yum_a),
    .yucky_cnt(yuk_a), .err_cnt(err_a), .alarm(alarm_a)
  );

  jelly_bean_taster #(.CNT_W(2), .YUCKY_LIMIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flavor(flavor), .color(color),
    .sugar_free(sugar_free), .sour(sour), .command(command),
    .taste(taste_b), .recipe(recipe_b), .yummy_cnt(yum_b),
    .yucky_cnt(yuk_b), .err_cnt(err_b), .alarm(alarm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = dut_a, index 1 = dut_b
  int cmax [2] = '{255, 3};
  int lim  [2] = '{3, 1};
  int m_yum [2], m_yuk [2], m_err [2], m_streak [2];
  int m_alarm [2], m_verdict [2], m_taste [2], m_recipe [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_yum[i] = 0; m_yuk[i] = 0; m_err[i] = 0; m_streak[i] = 0;
      m_alarm[i] = 0; m_verdict[i] = 0; m_taste[i] = 0; m_recipe[i] = 0;
    end
  endtask

  task automatic model_apply(input int c, input int f, input int co, input int sf, input int so);
    for (int i = 0; i < 2; i++) begin
      int new_taste;
      new_taste = (c == 1) ? m_verdict[i] : 0;
      if (c == 2) begin
        if (f == 0 || f > 4 || co == 3) begin
          if (m_err[i] < cmax[i]) m_err[i]++;
        end else begin
          bit yk;
          m_recipe[i] = f * 16 + co * 4 + sf * 2 + so;
          yk = (f == 4 && so == 1) || (f == 3 && sf == 0 && co == 1);
          if (yk) begin
            m_verdict[i] = 2;
            if (m_yuk[i] < cmax[i]) m_yuk[i]++;
            if (m_streak[i] + 1 >= lim[i]) m_alarm[i] = 1;
            m_streak[i] = (m_streak[i] + 1 > lim[i]) ? lim[i] : m_streak[i] + 1;
          end else begin
            m_verdict[i] = 1;
            if (m_yum[i] < cmax[i]) m_yum[i]++;
            m_streak[i] = 0;
          end
        end
      end else if (c == 3) begin
        m_yum[i] = 0; m_yuk[i] = 0; m_err[i] = 0; m_streak[i] = 0;
        m_alarm[i] = 0; m_verdict[i] = 0; m_recipe[i] = 0;
      end
      m_taste[i] = new_taste;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string tag);
    check({tag, " a.taste"},  32'(taste_a),  32'(m_taste[0]));
    check({tag, " a.recipe"}, 32'(recipe_a), 32'(m_recipe[0]));
    check({tag, " a.yummy"},  32'(yum_a),    32'(m_yum[0]));
    check({tag, " a.yucky"},  32'(yuk_a),    32'(m_yuk[0]));
    check({tag, " a.err"},    32'(err_a),    32'(m_err[0]));
    check({tag, " a.alarm"},  32'(alarm_a),  32'(m_alarm[0]));
    check({tag, " b.taste"},  32'(taste_b),  32'(m_taste[1]));
    check({tag, " b.recipe"}, 32'(recipe_b), 32'(m_recipe[1]));
    check({tag, " b.yummy"},  32'(yum_b),    32'(m_yum[1]));
    check({tag, " b.yucky"},  32'(yuk_b),    32'(m_yuk[1]));
    check({tag, " b.err"},    32'(err_b),    32'(m_err[1]));
    check({tag, " b.alarm"},  32'(alarm_b),  32'(m_alarm[1]));
  endtask

  task automatic step(input string tag, input int c, input int f, input int co,
                      input int sf, input int so);
    command    = 2'(c);
    flavor     = 3'(f);
    color      = 2'(co);
    sugar_free = 1'(sf);
    sour       = 1'(so);
    @(posedge clk);
    model_apply(c, f, co, sf, so);
    @(negedge clk);
    check_all(tag);
  endtask

  // Shorthands for common beans: yummy apple/red, yucky sour chocolate
  task automatic wr_yummy(input string tag); step(tag, 2, 1, 0, 0, 0); endtask
  task automatic wr_yucky(input string tag); step(tag, 2, 4, 0, 0, 1); endtask

  initial begin
    rst_n = 1'b0;
    command = 2'd0; flavor = 3'd0; color = 2'd0; sugar_free = 1'b0; sour = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    step("post_reset", 0, 0, 0, 0, 0);

    // 1: single write, read back, taste drops after one cycle
    step("t1_write", 2, 1, 0, 0, 0);
    step("t1_read", 1, 0, 0, 0, 0);
    check("t1 taste yummy", 32'(taste_a), 32'd1);
    step("t1_nop", 0, 0, 0, 0, 0);
    check("t1 taste back to unknown", 32'(taste_a), 32'd0);
    check("t1 recipe", 32'(recipe_a), 32'b001_00_0_0);
    check("t1 yummy_cnt", 32'(yum_a), 32'd1);

    // 2: three yucky in a row raise alarm; yummy keeps it; clear drops all
    step("t2_clear", 3, 0, 0, 0, 0);
    wr_yucky("t2_yk1");
    wr_yucky("t2_yk2");
    check("t2 alarm before limit", 32'(alarm_a), 32'd0);
    wr_yucky("t2_yk3");
    check("t2 alarm at limit", 32'(alarm_a), 32'd1);
    check("t2 yucky_cnt", 32'(yuk_a), 32'd3);
    wr_yummy("t2_ym");
    check("t2 alarm sticky", 32'(alarm_a), 32'd1);
    step("t2_clear2", 3, 0, 0, 0, 0);
    check("t2 alarm cleared", 32'(alarm_a), 32'd0);
    step("t2_read_after_clear", 1, 0, 0, 0, 0);
    check("t2 read after clear", 32'(taste_a), 32'd0);

    // 3: a yummy bean breaks the streak
    wr_yucky("t3_a"); wr_yucky("t3_b"); wr_yummy("t3_c");
    wr_yucky("t3_d"); wr_yucky("t3_e");
    check("t3 alarm", 32'(alarm_a), 32'd0);
    check("t3 yucky_cnt", 32'(yuk_a), 32'd4);

    // 4: rejected writes; then write-read returns the new verdict
    step("t4_clear", 3, 0, 0, 0, 0);
    wr_yummy("t4_good");
    step("t4_fl0", 2, 0, 1, 0, 0);
    step("t4_fl6", 2, 6, 1, 0, 0);
    step("t4_co3", 2, 2, 3, 0, 0);
    check("t4 err_cnt", 32'(err_a), 32'd3);
    check("t4 recipe kept", 32'(recipe_a), 32'b001_00_0_0);
    step("t4_bg_yucky", 2, 3, 1, 0, 0);
    step("t4_read", 1, 0, 0, 0, 0);
    check("t4 write-read verdict", 32'(taste_a), 32'd2);
    step("t4_read2", 1, 0, 0, 0, 0);
    check("t4 back-to-back read", 32'(taste_a), 32'd2);

    // 5: saturation on the narrow instance, then an async reset pulse
    step("t5_clear", 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) wr_yummy("t5_yummy");
    check("t5 narrow yummy saturated", 32'(yum_b), 32'd3);
    step("t5_read", 1, 0, 0, 0, 0);
    command = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_async_reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_apply(0, 0, 0, 0, 0);
    @(negedge clk);
    check_all("t5_after_release");

    // Random traffic, biased toward legal flavors
    for (int n = 0; n < 400; n++) begin
      int c, f, co;
      c  = int'($urandom_range(0, 3));
      if (c == 3 && $urandom_range(0, 3) != 0) c = 2;
      f  = ($urandom_range(0, 4) != 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 7));
      co = int'($urandom_range(0, 3));
      step("rand", c, f, co, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
